// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file write port: fixed A-over-B priority,
// a starvation counter that forces B through, and a pending-destination mask.
module regfile_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_valid,
  input  logic [ADDR_W-1:0]    a_rd,
  input  logic [DATA_W-1:0]    a_data,
  output logic                 a_ready,
  input  logic                 b_valid,
  input  logic [ADDR_W-1:0]    b_rd,
  input  logic [DATA_W-1:0]    b_data,
  output logic                 b_ready,
  input  logic                 b_issue,
  input  logic [ADDR_W-1:0]    b_issue_rd,
  output logic                 reg_write,
  output logic [ADDR_W-1:0]    write_reg,
  output logic [DATA_W-1:0]    write_data,
  output logic [2**ADDR_W-1:0] pend_mask
);

  localparam int NREG  = 2**ADDR_W;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  // Handshake: a source transfers in a cycle where its valid and ready are both
  // high; ready is a pure function of this cycle's valids and never precedes valid.
  logic [CNT_W-1:0]  starve_cnt;
  logic              starve_at_max;
  logic              grant_a;
  logic              grant_b;
  logic [ADDR_W-1:0] win_rd;
  logic [DATA_W-1:0] win_data;
  logic              commit;
  logic [NREG-1:0]   pend_next;

  assign starve_at_max = (starve_cnt == CNT_W'(STARVE_MAX));

  always_comb begin
    grant_b  = b_valid && (!a_valid || starve_at_max);
    grant_a  = a_valid && !grant_b;
    win_rd   = grant_b ? b_rd : a_rd;
    win_data = grant_b ? b_data : a_data;
    // Writes to x0 complete the handshake but never reach the register file.
    commit   = (grant_a || grant_b) && (win_rd != '0);
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Issue is applied after the clear so a same-edge set on the same index wins.
  always_comb begin
    pend_next = pend_mask;
    if (grant_b) pend_next[b_rd] = 1'b0;
    if (b_issue) pend_next[b_issue_rd] = 1'b1;
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      reg_write  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      pend_mask  <= '0;
    end else begin
      if (!b_valid || grant_b)
        starve_cnt <= '0;
      else if (!starve_at_max)
        starve_cnt <= starve_cnt + 1'b1;

      reg_write <= commit;
      if (commit) begin
        write_reg  <= win_rd;
        write_data <= win_data;
      end
      pend_mask <= pend_next;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter with hand-computed
// expectations, plus hand-written reset sequences.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_valid;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic        b_ready;
  logic        b_issue;
  logic [4:0]  b_issue_rd;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [31:0] pend_mask;

  int tests_run;
  int tests_failed;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_MAX(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_valid    (a_valid),
    .a_rd       (a_rd),
    .a_data     (a_data),
    .a_ready    (a_ready),
    .b_valid    (b_valid),
    .b_rd       (b_rd),
    .b_data     (b_data),
    .b_ready    (b_ready),
    .b_issue    (b_issue),
    .b_issue_rd (b_issue_rd),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .pend_mask  (pend_mask)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  brd;
    logic [31:0] bd;
    logic        bi;
    logic [4:0]  bird;
    logic        ear;
    logic        ebr;
    logic        erw;
    logic [4:0]  ewr;
    logic [31:0] ewd;
    logic [31:0] epm;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic av, input logic [4:0] ard, input logic [31:0] ad,
    input logic bv, input logic [4:0] brd, input logic [31:0] bd,
    input logic bi, input logic [4:0] bird,
    input logic ear, input logic ebr, input logic erw,
    input logic [4:0] ewr, input logic [31:0] ewd, input logic [31:0] epm);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad;
    v.bv = bv; v.brd = brd; v.bd = bd;
    v.bi = bi; v.bird = bird;
    v.ear = ear; v.ebr = ebr; v.erw = erw;
    v.ewr = ewr; v.ewd = ewd; v.epm = epm;
    return v;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s (step %0d): got 0x%08h, expected 0x%08h", name, idx, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                       input logic bi, input logic [4:0] bird);
    a_valid = av; a_rd = ard; a_data = ad;
    b_valid = bv; b_rd = brd; b_data = bd;
    b_issue = bi; b_issue_rd = bird;
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    drive(v.av, v.ard, v.ad, v.bv, v.brd, v.bd, v.bi, v.bird);
    #1;
    chk("a_ready", idx, {31'd0, a_ready}, {31'd0, v.ear});
    chk("b_ready", idx, {31'd0, b_ready}, {31'd0, v.ebr});
    @(posedge clk);
    #1;
    chk("reg_write", idx, {31'd0, reg_write}, {31'd0, v.erw});
    chk("write_reg", idx, {27'd0, write_reg}, {27'd0, v.ewr});
    chk("write_data", idx, write_data, v.ewd);
    chk("pend_mask", idx, pend_mask, v.epm);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

    // Reset held two cycles while A is presenting a write.
    @(negedge clk);
    drive(1'b1, 5'd4, 32'h0000_0001, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_reg_write", 0, {31'd0, reg_write}, 32'd0);
    chk("rst_write_reg", 0, {27'd0, write_reg}, 32'd0);
    chk("rst_write_data", 0, write_data, 32'd0);
    chk("rst_pend_mask", 0, pend_mask, 32'd0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    rst_n = 1'b1;

    //             A: v rd data          B: v rd data          issue     ar br rw  wr     wd             pm
    vecs.push_back(mk(1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,     0, 5'd0,  1, 0, 1, 5'd5,  32'hDEADBEEF, 32'h0));
    vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,     0, 5'd0,  0, 0, 0, 5'd5,  32'hDEADBEEF, 32'h0));
    vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,     1, 5'd7,  0, 0, 0, 5'd5,  32'hDEADBEEF, 32'h80));
    vecs.push_back(mk(0, 5'd0,  32'h0,        1, 5'd7,  32'h12,    0, 5'd0,  0, 1, 1, 5'd7,  32'h12,       32'h0));
    // Starvation: A wins three times, then B is forced through.
    vecs.push_back(mk(1, 5'd1,  32'h100,      1, 5'd2,  32'h200,   0, 5'd0,  1, 0, 1, 5'd1,  32'h100,      32'h0));
    vecs.push_back(mk(1, 5'd11, 32'h101,      1, 5'd2,  32'h200,   0, 5'd0,  1, 0, 1, 5'd11, 32'h101,      32'h0));
    vecs.push_back(mk(1, 5'd12, 32'h102,      1, 5'd2,  32'h200,   0, 5'd0,  1, 0, 1, 5'd12, 32'h102,      32'h0));
    vecs.push_back(mk(1, 5'd13, 32'h103,      1, 5'd2,  32'h200,   0, 5'd0,  0, 1, 1, 5'd2,  32'h200,      32'h0));
    vecs.push_back(mk(1, 5'd14, 32'h104,      1, 5'd2,  32'h200,   0, 5'd0,  1, 0, 1, 5'd14, 32'h104,      32'h0));
    vecs.push_back(mk(0, 5'd0,  32'h0,        1, 5'd2,  32'h201,   0, 5'd0,  0, 1, 1, 5'd2,  32'h201,      32'h0));
    // Same-edge set/clear of index 9, then issue to x0.
    vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,     1, 5'd9,  0, 0, 0, 5'd2,  32'h201,      32'h200));
    vecs.push_back(mk(0, 5'd0,  32'h0,        1, 5'd9,  32'h99,    1, 5'd9,  0, 1, 1, 5'd9,  32'h99,       32'h200));
    vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,     1, 5'd0,  0, 0, 0, 5'd9,  32'h99,       32'h200));
    vecs.push_back(mk(0, 5'd0,  32'h0,        1, 5'd9,  32'h55,    0, 5'd0,  0, 1, 1, 5'd9,  32'h55,       32'h0));
    // x0 writes from both sources complete the handshake without a write.
    vecs.push_back(mk(1, 5'd0,  32'hFFFFFFFF, 0, 5'd0,  32'h0,     0, 5'd0,  1, 0, 0, 5'd9,  32'h55,       32'h0));
    vecs.push_back(mk(0, 5'd0,  32'h0,        1, 5'd0,  32'h77,    0, 5'd0,  0, 1, 0, 5'd9,  32'h55,       32'h0));
    // Re-issue to a pending index; A writes to it leave the mask alone.
    vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,     1, 5'd20, 0, 0, 0, 5'd9,  32'h55,       32'h100000));
    vecs.push_back(mk(1, 5'd20, 32'hAA,       0, 5'd0,  32'h0,     1, 5'd20, 1, 0, 1, 5'd20, 32'hAA,       32'h100000));
    vecs.push_back(mk(0, 5'd0,  32'h0,        1, 5'd20, 32'hBB,    0, 5'd0,  0, 1, 1, 5'd20, 32'hBB,       32'h0));
    // Counter clears when b_valid drops, so B must wait a full three denials again.
    vecs.push_back(mk(1, 5'd21, 32'hA19,      1, 5'd22, 32'hB22,   0, 5'd0,  1, 0, 1, 5'd21, 32'hA19,      32'h0));
    vecs.push_back(mk(1, 5'd21, 32'hA20,      1, 5'd22, 32'hB22,   0, 5'd0,  1, 0, 1, 5'd21, 32'hA20,      32'h0));
    vecs.push_back(mk(1, 5'd21, 32'hA21,      0, 5'd0,  32'h0,     0, 5'd0,  1, 0, 1, 5'd21, 32'hA21,      32'h0));
    vecs.push_back(mk(1, 5'd21, 32'hA22,      1, 5'd22, 32'hB22,   0, 5'd0,  1, 0, 1, 5'd21, 32'hA22,      32'h0));
    vecs.push_back(mk(1, 5'd21, 32'hA23,      1, 5'd22, 32'hB22,   0, 5'd0,  1, 0, 1, 5'd21, 32'hA23,      32'h0));
    vecs.push_back(mk(1, 5'd21, 32'hA24,      1, 5'd22, 32'hB22,   0, 5'd0,  1, 0, 1, 5'd21, 32'hA24,      32'h0));
    vecs.push_back(mk(1, 5'd21, 32'hA25,      1, 5'd22, 32'hB22,   0, 5'd0,  0, 1, 1, 5'd22, 32'hB22,      32'h0));
    // Pending entry to be wiped by the mid-operation reset below.
    vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,     1, 5'd6,  0, 0, 0, 5'd22, 32'hB22,      32'h40));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i + 1);

    // Reset on the edge that would commit an A write to r3.
    @(negedge clk);
    drive(1'b1, 5'd3, 32'h0000_0033, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6);
    rst_n = 1'b0;
    #1;
    chk("midrst_a_ready", 100, {31'd0, a_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("midrst_reg_write", 100, {31'd0, reg_write}, 32'd0);
    chk("midrst_write_reg", 100, {27'd0, write_reg}, 32'd0);
    chk("midrst_write_data", 100, write_data, 32'd0);
    chk("midrst_pend_mask", 100, pend_mask, 32'd0);

    // After reset the starve counter is zero: contention goes to A.
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 5'd3, 32'h0000_0034, 1'b1, 5'd4, 32'h0000_0044, 1'b0, 5'd0);
    #1;
    chk("post_a_ready", 101, {31'd0, a_ready}, 32'd1);
    chk("post_b_ready", 101, {31'd0, b_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("post_reg_write", 101, {31'd0, reg_write}, 32'd1);
    chk("post_write_reg", 101, {27'd0, write_reg}, 32'd3);
    chk("post_write_data", 101, write_data, 32'h0000_0034);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
